// File: rtl/ps2_pkg.sv
// Shared scan-code constants and types for the PS/2 movement decoder.
// Scan code set 2, make codes only; break prefix is F0, extended prefix E0.
package ps2_pkg;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_seq_t;

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    typedef struct packed {
        logic a_l;
        logic arr_l;
        logic d_r;
        logic arr_r;
        logic w_j;
        logic spc_j;
        logic arr_u;
    } held_t;

    function automatic logic is_std(input logic [7:0] code);
        return (code == SC_A) || (code == SC_D) ||
               (code == SC_W) || (code == SC_SPACE);
    endfunction

    function automatic logic is_ext(input logic [7:0] code);
        return (code == SC_LEFT) || (code == SC_RIGHT) ||
               (code == SC_UP);
    endfunction

endpackage

// File: rtl/ps2_silence_timer.sv
// Counts clk cycles since the last received byte and raises a one-cycle
// flush request when the silence reaches STUCK_TIMEOUT cycles.
module ps2_silence_timer #(
    parameter int unsigned STUCK_TIMEOUT = 65_000_000,
    parameter int unsigned TO_W          = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_valid,
    output logic flush
);

    localparam bit            EN    = (STUCK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(STUCK_TIMEOUT);
    localparam logic [TO_W-1:0] LAST  = TO_W'(STUCK_TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear on a byte, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!EN || rx_valid) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    assign flush = EN && !rx_valid && (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns PS/2 set-2 scan-code bytes into held left/right/jump commands,
// with last-pressed-wins for left+right and a stuck-key silence flush.
module ps2_move_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned STUCK_TIMEOUT = 65_000_000,
    parameter int unsigned TO_W          = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       stepleft,
    output logic       stepright,
    output logic       stepjump,
    output logic       proto_err
);

    ps2_seq_t state_q, state_d;
    held_t    held_q, held_d;
    dir_t     dir_q, dir_d;

    logic perr_d;
    logic left_d, right_d, jump_d;
    logic stepleft_q, stepright_q, stepjump_q, proto_err_q;
    logic flush;
    logic do_upd;
    logic upd_val;
    logic left_held, right_held;

    ps2_silence_timer #(
        .STUCK_TIMEOUT(STUCK_TIMEOUT),
        .TO_W         (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .flush   (flush)
    );

    // Sequence tracking, held-bit update and next output values.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        dir_d   = dir_q;
        perr_d  = 1'b0;
        do_upd  = 1'b0;
        upd_val = 1'b0;

        if (flush) begin
            held_d  = '0;
            state_d = IDLE;
        end else if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == SC_BRK) begin
                        state_d = BRK;
                    end else if (rx_data == SC_EXT) begin
                        state_d = EXT;
                    end else if (is_std(rx_data)) begin
                        do_upd  = 1'b1;
                        upd_val = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == SC_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data == SC_EXT) begin
                        perr_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (is_ext(rx_data)) begin
                            do_upd  = 1'b1;
                            upd_val = 1'b1;
                        end
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (rx_data == SC_EXT || rx_data == SC_BRK) begin
                        perr_d = 1'b1;
                    end else if (is_std(rx_data)) begin
                        do_upd = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (rx_data == SC_EXT || rx_data == SC_BRK) begin
                        perr_d = 1'b1;
                    end else if (is_ext(rx_data)) begin
                        do_upd = 1'b1;
                    end
                end
            endcase
        end

        // Codes are disjoint, so the classification above picks the bank.
        if (do_upd) begin
            case (rx_data)
                SC_A:     held_d.a_l   = upd_val;
                SC_LEFT:  held_d.arr_l = upd_val;
                SC_D:     held_d.d_r   = upd_val;
                SC_RIGHT: held_d.arr_r = upd_val;
                SC_W:     held_d.w_j   = upd_val;
                SC_SPACE: held_d.spc_j = upd_val;
                SC_UP:    held_d.arr_u = upd_val;
                default:  ;
            endcase
            if (upd_val) begin
                if (rx_data == SC_A || rx_data == SC_LEFT) begin
                    dir_d = DIR_LEFT;
                end else if (rx_data == SC_D || rx_data == SC_RIGHT) begin
                    dir_d = DIR_RIGHT;
                end
            end
        end

        left_held  = held_d.a_l | held_d.arr_l;
        right_held = held_d.d_r | held_d.arr_r;
        left_d  = left_held & (~right_held | (dir_d == DIR_LEFT));
        right_d = right_held & (~left_held | (dir_d == DIR_RIGHT));
        jump_d  = held_d.w_j | held_d.spc_j | held_d.arr_u;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            held_q      <= '0;
            dir_q       <= DIR_RIGHT;
            stepleft_q  <= 1'b0;
            stepright_q <= 1'b0;
            stepjump_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            dir_q       <= dir_d;
            stepleft_q  <= left_d;
            stepright_q <= right_d;
            stepjump_q  <= jump_d;
            proto_err_q <= perr_d;
        end
    end

    assign stepleft  = stepleft_q;
    assign stepright = stepright_q;
    assign stepjump  = stepjump_q;
    assign proto_err = proto_err_q;

endmodule
